acq_sequencer: RTL and testbench

Parametrised acquisition sequencer for NCH ADC channels. It replaces the hard-coded setup counter in the board top level. On command it clears the ADC FIFO, loads per-channel ADC control words, enables the masked channels and loads the AGC DAC, then runs for a programmable window in one-shot or looping mode. It also generates the registered block-ready flag for the host link from the FIFO write count.

---
 rtl/acq_pkg.sv | 18 +
 rtl/acq_blk_rdy.sv | 39 +++
 rtl/acq_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_acq_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// acq_pkg: shared definitions for the acquisition sequencer family.
//   acq_state_t  - sequencer state encoding (IDLE=0 .. RUN=4)
//   CTRL_RESET   - ADC control word driven to every lane out of reset
//   AGC_RESET    - AGC DAC code driven out of reset
package acq_pkg;

    typedef enum logic [2:0] {
        AcqIdle   = 3'd0,
        AcqClear  = 3'd1,
        AcqLoad   = 3'd2,
        AcqSettle = 3'd3,
        AcqRun    = 3'd4
    } acq_state_t;

    localparam logic [9:0]  CTRL_RESET = 10'b0010000011;
    localparam logic [11:0] AGC_RESET  = 12'h333;

endpackage

// File: rtl/acq_blk_rdy.sv
// acq_blk_rdy: registered "at least one full host block buffered" flag.
//   clk, arstn  - clock, asynchronous active-low reset
//   clr_i       - FIFO clear for the coming cycle; forces the flag low
//   wrcnt_i     - FIFO write-side fill count (words)
//   blk_rdy_o   - wrcnt * BYTES_PER_WORD >= BLOCKSIZE, one cycle late
module acq_blk_rdy #(
    parameter int unsigned WRCNT_W        = 12,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned BLOCKSIZE      = 8192
) (
    input  logic               clk,
    input  logic               arstn,
    input  logic               clr_i,
    input  logic [WRCNT_W-1:0] wrcnt_i,
    output logic               blk_rdy_o
);

    // One spare bit beyond the exact product width so the multiply never wraps.
    localparam int unsigned PW = WRCNT_W + $clog2(BYTES_PER_WORD) + 1;
    localparam int unsigned CW = (PW > 32) ? PW : 32;

    logic [PW-1:0] bytes;
    logic          full;
    logic          blk_rdy_q;

    assign bytes = PW'(wrcnt_i) * PW'(BYTES_PER_WORD);
    assign full  = CW'(bytes) >= CW'(BLOCKSIZE);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            blk_rdy_q <= 1'b0;
        end else begin
            blk_rdy_q <= clr_i ? 1'b0 : full;
        end
    end

    assign blk_rdy_o = blk_rdy_q;

endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: ADC acquisition sequencer (CLEAR -> LOAD -> SETTLE -> RUN).
//   start_i/stop_i      - single-cycle start / abort commands
//   loop_mode_i         - restart at CLEAR when RUN expires (sampled at expiry)
//   ch_mask_i, ctrlword_in_i, agc_level_i - latched on an accepted start
//   fifo_wrcnt_i        - FIFO write count, drives blk_rdy_o
//   adc_*_o, agc_*_o    - ADC control/enable and AGC DAC load outputs
//   fifo_clr_o          - FIFO clear during CLEAR
//   blk_rdy_o, busy_o, state_o - status
// All outputs are registered; they are computed from the next state.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int unsigned NCH            = 2,
    parameter int unsigned CTRL_W         = 10,
    parameter int unsigned AGC_W          = 12,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned CLR_CYCLES     = 4,
    parameter int unsigned T_LOAD         = 100,
    parameter int unsigned T_SETTLE       = 900,
    parameter int unsigned T_RUN          = 1000000000,
    parameter int unsigned WRCNT_W        = 12,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned BLOCKSIZE      = 8192
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  loop_mode_i,
    input  logic [NCH-1:0]        ch_mask_i,
    input  logic [NCH*CTRL_W-1:0] ctrlword_in_i,
    input  logic [AGC_W-1:0]      agc_level_i,
    input  logic [WRCNT_W-1:0]    fifo_wrcnt_i,
    output logic [NCH*CTRL_W-1:0] adc_ctrlword_o,
    output logic [NCH-1:0]        adc_ldctrl_o,
    output logic [NCH-1:0]        adc_enable_o,
    output logic [AGC_W-1:0]      agc_data_o,
    output logic                  agc_load_o,
    output logic                  fifo_clr_o,
    output logic                  blk_rdy_o,
    output logic                  busy_o,
    output logic [2:0]            state_o
);

    localparam logic [2:0] StIdle   = AcqIdle;
    localparam logic [2:0] StClear  = AcqClear;
    localparam logic [2:0] StLoad   = AcqLoad;
    localparam logic [2:0] StSettle = AcqSettle;
    localparam logic [2:0] StRun    = AcqRun;

    // Timer holds "cycles left in phase minus one"; zero marks the last cycle.
    localparam bit               RunForever = (T_RUN == 0);
    localparam logic [CNT_W-1:0] ClrLast    = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] LoadLast   = CNT_W'(T_LOAD - 1);
    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(T_SETTLE - 1);
    localparam logic [CNT_W-1:0] RunLast    = RunForever ? '0 : CNT_W'(T_RUN - 1);

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic [NCH-1:0]        mask_q, mask_d;
    logic [NCH*CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [AGC_W-1:0]      agc_q, agc_d;
    logic [NCH-1:0]        ldctrl_q, enable_q;
    logic                  agc_load_q, fifo_clr_q, busy_q;
    logic                  last;
    logic                  fifo_clr_d;

    assign last = (timer_q == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        mask_d  = mask_q;
        ctrl_d  = ctrl_q;
        agc_d   = agc_q;
        if (!last) begin
            timer_d = timer_q - 1'b1;
        end
        if (stop_i) begin
            // Abort from any state; in IDLE this also discards a same-cycle start.
            state_d = StIdle;
            timer_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i && (|ch_mask_i)) begin
                        state_d = StClear;
                        timer_d = ClrLast;
                        mask_d  = ch_mask_i;
                        ctrl_d  = ctrlword_in_i;
                        agc_d   = agc_level_i;
                    end
                end
                StClear: begin
                    if (last) begin
                        state_d = StLoad;
                        timer_d = LoadLast;
                    end
                end
                StLoad: begin
                    if (last) begin
                        state_d = StSettle;
                        timer_d = SettleLast;
                    end
                end
                StSettle: begin
                    if (last) begin
                        state_d = StRun;
                        timer_d = RunLast;
                    end
                end
                StRun: begin
                    if (!RunForever && last) begin
                        if (loop_mode_i) begin
                            state_d = StClear;
                            timer_d = ClrLast;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            endcase
        end
    end

    assign fifo_clr_d = (state_d == StClear);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            mask_q     <= '0;
            ctrl_q     <= {NCH{CTRL_W'(CTRL_RESET)}};
            agc_q      <= AGC_W'(AGC_RESET);
            ldctrl_q   <= '0;
            enable_q   <= '0;
            agc_load_q <= 1'b0;
            fifo_clr_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            mask_q     <= mask_d;
            ctrl_q     <= ctrl_d;
            agc_q      <= agc_d;
            ldctrl_q   <= (state_d == StLoad && timer_d == '0) ? mask_d : '0;
            enable_q   <= (state_d == StRun) ? mask_d : '0;
            // RUN is only ever entered from SETTLE, so this is the first RUN cycle.
            agc_load_q <= (state_d == StRun) && (state_q != StRun);
            fifo_clr_q <= fifo_clr_d;
            busy_q     <= (state_d != StIdle);
        end
    end

    acq_blk_rdy #(
        .WRCNT_W        (WRCNT_W),
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .BLOCKSIZE      (BLOCKSIZE)
    ) u_blk_rdy (
        .clk       (clk),
        .arstn     (arstn),
        .clr_i     (fifo_clr_d),
        .wrcnt_i   (fifo_wrcnt_i),
        .blk_rdy_o (blk_rdy_o)
    );

    assign adc_ctrlword_o = ctrl_q;
    assign adc_ldctrl_o   = ldctrl_q;
    assign adc_enable_o   = enable_q;
    assign agc_data_o     = agc_q;
    assign agc_load_o     = agc_load_q;
    assign fifo_clr_o     = fifo_clr_q;
    assign busy_o         = busy_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: per-cycle expected outputs come from a schedule
// model (phase derived from the offset since sequence start) and are queued;
// a negedge monitor pops and compares.
module tb_acq_sequencer;

    localparam int C  = 2;
    localparam int TL = 3;
    localparam int TS = 4;
    localparam int TR = 10;
    localparam int P  = C + TL + TS + TR;

    localparam logic [19:0] CW_RST  = 20'b0010000011_0010000011;
    localparam logic [11:0] AGC_RST = 12'h333;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        start = 1'b0, stop = 1'b0, loop_mode = 1'b0;
    logic [1:0]  ch_mask = '0;
    logic [19:0] ctrlword_in = '0;
    logic [11:0] agc_level = '0, fifo_wrcnt = '0;
    logic [19:0] adc_ctrlword;
    logic [1:0]  adc_ldctrl, adc_enable;
    logic [11:0] agc_data;
    logic        agc_load, fifo_clr, blk_rdy, busy;
    logic [2:0]  state;

    always #5 clk = ~clk;

    acq_sequencer #(
        .NCH        (2),
        .CLR_CYCLES (C),
        .T_LOAD     (TL),
        .T_SETTLE   (TS),
        .T_RUN      (TR)
    ) dut (
        .clk            (clk),
        .arstn          (arstn),
        .start_i        (start),
        .stop_i         (stop),
        .loop_mode_i    (loop_mode),
        .ch_mask_i      (ch_mask),
        .ctrlword_in_i  (ctrlword_in),
        .agc_level_i    (agc_level),
        .fifo_wrcnt_i   (fifo_wrcnt),
        .adc_ctrlword_o (adc_ctrlword),
        .adc_ldctrl_o   (adc_ldctrl),
        .adc_enable_o   (adc_enable),
        .agc_data_o     (agc_data),
        .agc_load_o     (agc_load),
        .fifo_clr_o     (fifo_clr),
        .blk_rdy_o      (blk_rdy),
        .busy_o         (busy),
        .state_o        (state)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic        clr;
        logic [1:0]  ld;
        logic [1:0]  en;
        logic        agl;
        logic        busy;
        logic        blk;
        logic [11:0] agc;
        logic [19:0] cw;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: active flag plus the cycle at which the current pass began.
    bit          m_act;
    int          m_cyc = 0;
    int          m_seg;
    logic [1:0]  m_mask;
    logic [19:0] m_cw;
    logic [11:0] m_agc;
    bit          m_blk;

    function automatic void model_reset();
        m_act  = 1'b0;
        m_seg  = 0;
        m_mask = '0;
        m_cw   = CW_RST;
        m_agc  = AGC_RST;
        m_blk  = 1'b0;
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        int   off;
        o      = '0;
        o.agc  = m_agc;
        o.cw   = m_cw;
        o.blk  = m_blk;
        o.busy = m_act;
        if (m_act) begin
            off = m_cyc - m_seg;
            if (off < C) begin
                o.st  = 3'd1;
                o.clr = 1'b1;
            end else if (off < C + TL) begin
                o.st = 3'd2;
                if (off == C + TL - 1) o.ld = m_mask;
            end else if (off < C + TL + TS) begin
                o.st = 3'd3;
            end else begin
                o.st  = 3'd4;
                o.en  = m_mask;
                o.agl = (off == C + TL + TS);
            end
        end
        return o;
    endfunction

    function automatic void advance(input bit st, input bit sp, input bit lm,
                                    input logic [1:0] mk, input logic [19:0] cw,
                                    input logic [11:0] ag, input logic [11:0] wc);
        if (!m_act) begin
            if (st && !sp && mk != 2'b00) begin
                m_act  = 1'b1;
                m_seg  = m_cyc + 1;
                m_mask = mk;
                m_cw   = cw;
                m_agc  = ag;
            end
        end else if (sp) begin
            m_act = 1'b0;
        end else if (m_cyc - m_seg == P - 1) begin
            if (lm) m_seg = m_cyc + 1;
            else    m_act = 1'b0;
        end
        m_cyc++;
        m_blk = (m_act && (m_cyc - m_seg) < C) ? 1'b0 : (int'(wc) * 4 >= 8192);
    endfunction

    // Called at posedge+1: drive this cycle's inputs, queue this cycle's outputs.
    task automatic step(input bit st, input bit sp, input bit lm,
                        input logic [1:0] mk, input logic [11:0] wc);
        logic [19:0] cw;
        logic [11:0] ag;
        cw = 20'($urandom);
        ag = 12'($urandom);
        start = st; stop = sp; loop_mode = lm; ch_mask = mk;
        ctrlword_in = cw; agc_level = ag; fifo_wrcnt = wc;
        exp_q.push_back(model_out());
        advance(st, sp, lm, mk, cw, ag, wc);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int cycles);
        arstn = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        model_reset();
        repeat (cycles) begin
            exp_q.push_back(model_out());
            @(posedge clk);
            #1;
            m_cyc++;
        end
        arstn = 1'b1;
    endtask

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, req);
        end
    endfunction

    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("state",        32'(state),        32'(e.st));
            chk("fifo_clr",     32'(fifo_clr),     32'(e.clr));
            chk("adc_ldctrl",   32'(adc_ldctrl),   32'(e.ld));
            chk("adc_enable",   32'(adc_enable),   32'(e.en));
            chk("agc_load",     32'(agc_load),     32'(e.agl));
            chk("busy",         32'(busy),         32'(e.busy));
            chk("blk_rdy",      32'(blk_rdy),      32'(e.blk));
            chk("agc_data",     32'(agc_data),     32'(e.agc));
            chk("adc_ctrlword", 32'(adc_ctrlword), 32'(e.cw));
        end
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        pulse_reset(3);

        // Idle after reset: everything at reset values.
        repeat (100) step(0, 0, 0, 2'b11, 12'd0);

        // One-shot, both channels.
        step(1, 0, 0, 2'b11, 12'd0);
        repeat (22) step(0, 0, 0, 2'b11, 12'd0);

        // Looping, channel 0 only, stop in the second RUN pass (cycle 33).
        step(1, 0, 1, 2'b01, 12'd0);
        for (int c = 1; c <= 33; c++) step(0, c == 33, 1, 2'b01, 12'd0);
        repeat (4) step(0, 0, 0, 2'b01, 12'd0);

        // start+stop together, and start with an empty mask: both ignored.
        step(1, 1, 0, 2'b11, 12'd0);
        repeat (2) step(0, 0, 0, 2'b11, 12'd0);
        step(1, 0, 0, 2'b00, 12'd0);
        repeat (3) step(0, 0, 0, 2'b00, 12'd0);

        // blk_rdy threshold and gating during CLEAR.
        repeat (3) step(0, 0, 0, 2'b00, 12'd2047);
        repeat (3) step(0, 0, 0, 2'b00, 12'd2048);
        step(1, 0, 0, 2'b10, 12'd2048);
        repeat (8) step(0, 0, 0, 2'b10, 12'd2048);
        repeat (3) step(0, 0, 0, 2'b10, 12'd4095);
        repeat (3) step(0, 0, 0, 2'b10, 12'd2047);
        repeat (8) step(0, 0, 0, 2'b10, 12'd0);

        // Reset during SETTLE, then a full fresh sequence.
        step(1, 0, 0, 2'b10, 12'd0);
        repeat (7) step(0, 0, 0, 2'b10, 12'd0);
        pulse_reset(2);
        step(1, 0, 0, 2'b11, 12'd0);
        repeat (22) step(0, 0, 0, 2'b11, 12'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit          st, sp, lm;
            logic [1:0]  mk;
            logic [11:0] wc;
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 39) == 0);
            lm = 1'($urandom_range(0, 1));
            mk = 2'($urandom);
            wc = ($urandom_range(0, 1) == 1) ? 12'(2046 + $urandom_range(0, 3))
                                             : 12'($urandom);
            if ($urandom_range(0, 299) == 0) pulse_reset(1);
            else step(st, sp, lm, mk, wc);
        end

        repeat (2) step(0, 0, 0, 2'b00, 12'd0);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
